core_dbg_arbiter: RTL and testbench
===================================

# core_dbg_arbiter

Two-requester round-robin arbiter for the core debug register port (req / wr_rd / addr / wdata / rdata / rd_ready). It lets the JTAG-side APB debug slave and a second requester (on-chip self-debug or monitor) share one core debug register interface. Each requester sees the same pulse-request / rd_ready-response protocol it would see from the core directly. Requests are latched per port, granted one at a time, and reads are protected by a response timeout.

## Interface
- ADDR_WIDTH, 5, debug register address width
- DATA_WIDTH, 32, read/write data width
- TIMEOUT, 255, maximum sampling edges waiting for core_dbg_rd_ready (≥1)
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout
- clk  in  1  rising-edge clock; everything is in this single domain
- rst_n  in  1  reset, synchronous, active-low
- m0_req, m1_req  in  1  one-cycle request pulse
- m0_wr_rd, m1_wr_rd  in  1  1 = write, 0 = read; sampled with req
- m0_addr, m1_addr  in  ADDR_WIDTH  register address; sampled with req
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data; sampled with req
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data; registered, held until the next read completion on that port
- m0_rd_ready, m1_rd_ready  out  1  one-cycle pulse; rdata is valid in the same cycle
- m0_busy, m1_busy  out  1  port has a pending or in-service request
- core_dbg_req  out  1  downstream request; one transaction per high cycle
- core_dbg_wr_rd, core_dbg_addr, core_dbg_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  downstream command fields, valid while core_dbg_req is high, held afterwards
- core_dbg_rdata  in  DATA_WIDTH  downstream read data
- core_dbg_rd_ready  in  1  downstream read data valid
- timeout_err  out  1  one-cycle pulse on read timeout

## Operation
- **Reset values.** All outputs reset to 0 (rdata, addr, wdata, wr_rd, req, rd_ready, busy, timeout_err). Pending latches clear. State resets to IDLE. The round-robin pointer resets to last = 1, so port 0 wins the first tie.
- **Capture.** At an edge where mX_req = 1 and mX_busy = 0, latch wr_rd, addr and wdata, and set pendingX. A request that arrives while busy = 1 is dropped silently; there is no other side effect.
- **Busy.** mX_busy = pendingX | (state == WAIT_RD and owner == X). It is derived combinationally from registered state.
- **State IDLE.**
  - No pending request: core_dbg_req <= 0.
  - At least one pending request: choose the winner. If only one port is pending, that port wins. If both are pending, the port not granted last wins.
  - On grant: core_dbg_req <= 1, drive the winner's latched fields, clear its pending latch, update last and owner.
  - Write grant: stay in IDLE. The write is complete; no acknowledge is sent to the requester.
  - Read grant: go to WAIT_RD and clear the timeout counter.
- **State WAIT_RD.**
  - core_dbg_req <= 0.
  - At each edge, sample core_dbg_rd_ready.
  - If it is 1: m{owner}_rdata <= core_dbg_rdata, m{owner}_rd_ready <= 1, go to IDLE.
  - Otherwise increment the counter. At the TIMEOUT-th consecutive low sample: m{owner}_rdata <= ERR_DATA, m{owner}_rd_ready <= 1, timeout_err <= 1, go to IDLE.
  - The counter is $clog2(TIMEOUT+1) bits and never wraps.
- **Pulse hygiene.** mX_rd_ready and timeout_err default to 0 every cycle. The non-owner's rdata never changes.
- **Reset mid-operation.** Any in-flight read is abandoned: no rd_ready pulse is generated and both pending latches are lost. A late core_dbg_rd_ready after reset is ignored, because state is IDLE.

## Timing
- **Request to downstream.** mX_req sampled at edge E0 → pending visible after E0 → core_dbg_req high in cycle E1–E2 (grant at E1).
- **Read latency.** core_dbg_rd_ready is first sampled at E2, so a combinational downstream response is allowed. Minimum latency is m_rd_ready visible after E2, i.e. 2 cycles from the request edge.
- **Write throughput.** Writes issue at one per cycle. core_dbg_req may stay high for consecutive cycles, and each cycle is a separate transaction.
- **Read turnaround.** After a read completes at edge Ec, the next grant happens at Ec+1. There is one idle cycle on core_dbg_req.
- **Same-edge capture.** A port's own new request is accepted at the edge where its busy is already 0.
  - For a write, busy falls after the grant edge.
  - For a read, busy falls after the completion edge.
  - The other port can capture during any state.

## Test plan
- **Single read, port 0.** m0 reads addr 5'h03; downstream returns 32'h1234_5678 with rd_ready 1 cycle after req. Expect: m0_rd_ready pulse with m0_rdata = 32'h1234_5678; m1_rd_ready stays 0; m1_rdata is unchanged.
- **Single write, port 1.** m1 writes addr 5'h1F with data 32'hA5A5_0F0F. Expect: core_dbg_req is high exactly 1 cycle with wr_rd = 1, addr 5'h1F, wdata 32'hA5A5_0F0F; m1_busy falls the next cycle.
- **Simultaneous requests, round robin.** Both ports request writes every time busy is low, for 6 grants. Expect: grant order 0,1,0,1,0,1 and back-to-back core_dbg_req cycles.
- **Read timeout.** TIMEOUT = 4; m0 read with core_dbg_rd_ready held at 0. Expect: m0_rd_ready and timeout_err pulse together 4 sampling edges after the grant; m0_rdata = 32'hDEAD_BEEF; the next pending m1 request is then granted.
- **Request while busy.** While port 0's read is in WAIT_RD, pulse m0_req with addr 5'h07. Expect: it is dropped; after completion no second downstream transaction is issued for port 0.
- **Reset mid-read.** Assert rst_n = 0 for 1 cycle during WAIT_RD with m1 pending, then drive core_dbg_rd_ready = 1. Expect: all outputs are 0, no rd_ready pulses occur, and core_dbg_req stays 0.

Source files
------------

// File: rtl/core_dbg_arbiter.sv
// core_dbg_arbiter
//   Round-robin arbiter that lets two requesters (JTAG-side APB debug slave
//   and an on-chip self-debug/monitor master) share one core debug register
//   port. Each requester sees the plain pulse-request / rd_ready-response
//   protocol of the core. Requests are latched per port and granted one at a
//   time. Reads are guarded by a response timeout that returns ERR_DATA.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   mX_req/wr_rd/addr/wdata         requester X command (X = 0,1), sampled with req
//   mX_rdata, mX_rd_ready           requester X read data and one-cycle valid pulse
//   mX_busy                         requester X has a pending or in-service request
//   core_dbg_req/wr_rd/addr/wdata   downstream command (one transaction per req cycle)
//   core_dbg_rdata, core_dbg_rd_ready  downstream read response
//   timeout_err                     one-cycle pulse when a read times out
module core_dbg_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_wr_rd,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rd_ready,
  output logic                  m0_busy,
  input  logic                  m1_req,
  input  logic                  m1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rd_ready,
  output logic                  m1_busy,
  output logic                  core_dbg_req,
  output logic                  core_dbg_wr_rd,
  output logic [ADDR_WIDTH-1:0] core_dbg_addr,
  output logic [DATA_WIDTH-1:0] core_dbg_wdata,
  input  logic [DATA_WIDTH-1:0] core_dbg_rdata,
  input  logic                  core_dbg_rd_ready,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_RD} state_t;

  state_t state_q, state_d;

  // Per-port request latches
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            lat_wr_rd_q;
  logic [ADDR_WIDTH-1:0] lat_addr_q  [2];
  logic [DATA_WIDTH-1:0] lat_wdata_q [2];

  // Arbitration / read tracking
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // Registered outputs
  logic                  core_req_q, core_req_d;
  logic                  core_wr_rd_q, core_wr_rd_d;
  logic [ADDR_WIDTH-1:0] core_addr_q, core_addr_d;
  logic [DATA_WIDTH-1:0] core_wdata_q, core_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic [1:0]            rd_ready_q, rd_ready_d;
  logic                  tmo_q, tmo_d;

  // Input bundling
  logic [1:0]            in_req, in_wr_rd;
  logic [ADDR_WIDTH-1:0] in_addr  [2];
  logic [DATA_WIDTH-1:0] in_wdata [2];

  assign in_req      = {m1_req, m0_req};
  assign in_wr_rd    = {m1_wr_rd, m0_wr_rd};
  assign in_addr[0]  = m0_addr;
  assign in_addr[1]  = m1_addr;
  assign in_wdata[0] = m0_wdata;
  assign in_wdata[1] = m1_wdata;

  // Busy covers both the latched request and a read still being serviced.
  logic       in_service;
  logic [1:0] owner_oh;
  logic [1:0] busy;
  logic [1:0] cap;

  assign in_service = (state_q == WAIT_RD);
  assign owner_oh   = owner_q ? 2'b10 : 2'b01;
  assign busy       = pend_q | (owner_oh & {2{in_service}});
  assign cap        = in_req & ~busy;

  // Grant decision: a lone pending port wins; on a tie the port not served last wins.
  logic       grant_vld;
  logic       win;
  logic [1:0] grant_oh;
  logic       win_rd;
  logic       rsp_ok;
  logic       rsp_tmo;
  logic       rsp_done;

  assign grant_vld = (state_q == IDLE) && (|pend_q);
  assign win       = (&pend_q) ? ~last_q : pend_q[1];
  assign grant_oh  = grant_vld ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign win_rd    = ~lat_wr_rd_q[win];
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign rsp_ok    = in_service && core_dbg_rd_ready;
  assign rsp_tmo   = in_service && !core_dbg_rd_ready && (cnt_inc == CNT_W'(TIMEOUT));
  assign rsp_done  = rsp_ok || rsp_tmo;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld && win_rd) state_d = WAIT_RD;
      WAIT_RD: if (rsp_done)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / bookkeeping next values
  always_comb begin
    core_req_d   = grant_vld;
    core_wr_rd_d = core_wr_rd_q;
    core_addr_d  = core_addr_q;
    core_wdata_d = core_wdata_q;
    last_d       = last_q;
    owner_d      = owner_q;
    rd_ready_d   = 2'b00;
    tmo_d        = rsp_tmo;
    rdata_d[0]   = rdata_q[0];
    rdata_d[1]   = rdata_q[1];
    // Leaving WAIT_RD stores at most TIMEOUT, then IDLE clears it: no wrap.
    cnt_d        = in_service ? cnt_inc : '0;
    pend_d       = (pend_q & ~grant_oh) | cap;

    if (grant_vld) begin
      core_wr_rd_d = lat_wr_rd_q[win];
      core_addr_d  = lat_addr_q[win];
      core_wdata_d = lat_wdata_q[win];
      last_d       = win;
      owner_d      = win;
    end

    if (rsp_done) begin
      rd_ready_d       = owner_oh;
      rdata_d[owner_q] = rsp_ok ? core_dbg_rdata : ERR_DATA;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q       <= 2'b00;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      core_req_q   <= 1'b0;
      core_wr_rd_q <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
      rd_ready_q   <= 2'b00;
      tmo_q        <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      core_req_q   <= core_req_d;
      core_wr_rd_q <= core_wr_rd_d;
      core_addr_q  <= core_addr_d;
      core_wdata_q <= core_wdata_d;
      rdata_q[0]   <= rdata_d[0];
      rdata_q[1]   <= rdata_d[1];
      rd_ready_q   <= rd_ready_d;
      tmo_q        <= tmo_d;
    end
  end

  // Command fields are only consumed while pend_q is set, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) begin
        lat_wr_rd_q[i] <= in_wr_rd[i];
        lat_addr_q[i]  <= in_addr[i];
        lat_wdata_q[i] <= in_wdata[i];
      end
    end
  end

  assign m0_busy        = busy[0];
  assign m1_busy        = busy[1];
  assign m0_rdata       = rdata_q[0];
  assign m1_rdata       = rdata_q[1];
  assign m0_rd_ready    = rd_ready_q[0];
  assign m1_rd_ready    = rd_ready_q[1];
  assign core_dbg_req   = core_req_q;
  assign core_dbg_wr_rd = core_wr_rd_q;
  assign core_dbg_addr  = core_addr_q;
  assign core_dbg_wdata = core_wdata_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_core_dbg_arbiter.sv
// Testbench for core_dbg_arbiter: directed scenarios followed by randomized
// traffic. A transaction-level reference model predicts each clock edge and
// pushes the expected downstream commands, read responses and per-cycle
// output state into queues; an independent monitor pops and compares.
module tb_core_dbg_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  logic          mreq [2];
  logic          mwr  [2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mwd  [2];
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_rd_ready, m1_rd_ready, m0_busy, m1_busy;
  logic          core_dbg_req, core_dbg_wr_rd, timeout_err;
  logic [AW-1:0] core_dbg_addr;
  logic [DW-1:0] core_dbg_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_rdy;

  always #5 clk = ~clk;

  core_dbg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(mreq[0]), .m0_wr_rd(mwr[0]), .m0_addr(maddr[0]), .m0_wdata(mwd[0]),
    .m0_rdata(m0_rdata), .m0_rd_ready(m0_rd_ready), .m0_busy(m0_busy),
    .m1_req(mreq[1]), .m1_wr_rd(mwr[1]), .m1_addr(maddr[1]), .m1_wdata(mwd[1]),
    .m1_rdata(m1_rdata), .m1_rd_ready(m1_rd_ready), .m1_busy(m1_busy),
    .core_dbg_req(core_dbg_req), .core_dbg_wr_rd(core_dbg_wr_rd),
    .core_dbg_addr(core_dbg_addr), .core_dbg_wdata(core_dbg_wdata),
    .core_dbg_rdata(core_rdata), .core_dbg_rd_ready(core_rdy),
    .timeout_err(timeout_err)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  typedef struct { int e; logic wr; logic [AW-1:0] a; logic [DW-1:0] d; } core_t;
  typedef struct { int e; int port; logic [DW-1:0] d; logic tmo; } rsp_t;
  typedef struct { int e; logic [1:0] busy; logic [DW-1:0] rd0; logic [DW-1:0] rd1;
                   logic creq; logic [1:0] rdy; logic tmo; } st_t;

  core_t core_q[$];
  rsp_t  rsp_q[$];
  st_t   st_q[$];

  // Reference model: per-port optional request, the port whose read is in
  // flight (-1 if none), how many low samples it has seen, last winner.
  bit            pv [2];
  logic          pw [2];
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  logic [DW-1:0] mrd[2];
  int serving = -1;
  int waited  = 0;
  int last    = 1;

  // Predict the effect of the coming rising edge from the current inputs.
  task automatic model_step();
    int   e;
    int   win;
    bit   cap [2];
    st_t  s;
    e      = edge_n + 1;
    s.e    = e;
    s.creq = 1'b0;
    s.rdy  = 2'b00;
    s.tmo  = 1'b0;
    if (!rst_n) begin
      pv[0] = 0; pv[1] = 0;
      serving = -1; waited = 0; last = 1;
      mrd[0] = '0; mrd[1] = '0;
      s.busy = 2'b00; s.rd0 = '0; s.rd1 = '0;
      st_q.push_back(s);
      return;
    end
    for (int x = 0; x < 2; x++) cap[x] = mreq[x] && !(pv[x] || serving == x);
    if (serving < 0) begin
      if (pv[0] || pv[1]) begin
        win = (pv[0] && pv[1]) ? 1 - last : (pv[0] ? 0 : 1);
        core_q.push_back('{e, pw[win], pa[win], pd[win]});
        pv[win] = 0;
        last    = win;
        s.creq  = 1'b1;
        if (!pw[win]) begin serving = win; waited = 0; end
      end
    end else begin
      if (core_rdy) begin
        mrd[serving] = core_rdata;
        rsp_q.push_back('{e, serving, core_rdata, 1'b0});
        s.rdy[serving] = 1'b1;
        serving = -1;
      end else begin
        waited++;
        if (waited == TMO) begin
          mrd[serving] = ERR;
          rsp_q.push_back('{e, serving, ERR, 1'b1});
          s.rdy[serving] = 1'b1;
          s.tmo = 1'b1;
          serving = -1;
        end
      end
    end
    for (int x = 0; x < 2; x++) begin
      if (cap[x]) begin
        pv[x] = 1; pw[x] = mwr[x]; pa[x] = maddr[x]; pd[x] = mwd[x];
      end
    end
    s.busy = {pv[1] || serving == 1, pv[0] || serving == 0};
    s.rd0  = mrd[0];
    s.rd1  = mrd[1];
    st_q.push_back(s);
  endtask

  // Monitor: compares after every rising edge, independent of stimulus.
  initial begin
    st_t   s;
    core_t c;
    rsp_t  r;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("st_edge", 64'(edge_n), 64'(s.e));
        chk("busy", {m1_busy, m0_busy}, s.busy);
        chk("m0_rdata", m0_rdata, s.rd0);
        chk("m1_rdata", m1_rdata, s.rd1);
        chk("core_req", core_dbg_req, s.creq);
        chk("rd_ready", {m1_rd_ready, m0_rd_ready}, s.rdy);
        chk("timeout_err", timeout_err, s.tmo);
      end
      if (core_dbg_req === 1'b1) begin
        if (core_q.size() == 0) chk("unexpected_core_req", 1, 0);
        else begin
          c = core_q.pop_front();
          chk("core_edge", 64'(edge_n), 64'(c.e));
          chk("core_wr_rd", core_dbg_wr_rd, c.wr);
          chk("core_addr", core_dbg_addr, c.a);
          chk("core_wdata", core_dbg_wdata, c.d);
        end
      end
      if (m0_rd_ready === 1'b1 || m1_rd_ready === 1'b1) begin
        if (rsp_q.size() == 0) chk("unexpected_rd_ready", 1, 0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_edge", 64'(edge_n), 64'(r.e));
          chk("rsp_port", {m1_rd_ready, m0_rd_ready}, (r.port == 1) ? 2'b10 : 2'b01);
          chk("rsp_data", (r.port == 1) ? m1_rdata : m0_rdata, r.d);
          chk("rsp_tmo", timeout_err, r.tmo);
        end
      end
    end
  end

  bit auto_resp = 0;

  // One clock: optional random responder, model prediction, then advance.
  task automatic tick();
    if (auto_resp) begin
      core_rdy   = (serving >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      core_rdata = $urandom;
    end
    model_step();
    @(negedge clk);
    mreq[0] = 1'b0;
    mreq[1] = 1'b0;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mreq[p] = 1'b1; mwr[p] = wr; maddr[p] = a; mwd[p] = d;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_core"}, {core_dbg_req, core_dbg_wr_rd, core_dbg_addr, core_dbg_wdata}, '0);
    chk({name, "_m0"}, {m0_rdata, m0_rd_ready, m0_busy}, '0);
    chk({name, "_m1"}, {m1_rdata, m1_rd_ready, m1_busy}, '0);
    chk({name, "_tmo"}, timeout_err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    core_rdy = 1'b0;
    core_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      mreq[p] = 1'b0; mwr[p] = 1'b0; maddr[p] = '0; mwd[p] = '0;
    end
    @(negedge clk);
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single read on port 0
    set_req(0, 1'b0, 5'h03, '0);
    tick();
    tick();
    chk("t1_core_req", core_dbg_req, 1'b1);
    chk("t1_core_addr", core_dbg_addr, 5'h03);
    core_rdy = 1'b1; core_rdata = 32'h1234_5678;
    tick();
    core_rdy = 1'b0;
    chk("t1_m0_rd_ready", m0_rd_ready, 1'b1);
    chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("t1_m1_rd_ready", m1_rd_ready, 1'b0);
    chk("t1_m1_rdata", m1_rdata, 32'h0);
    tick();

    // Single write on port 1
    set_req(1, 1'b1, 5'h1F, 32'hA5A5_0F0F);
    tick();
    tick();
    chk("t2_core", {core_dbg_req, core_dbg_wr_rd, core_dbg_addr, core_dbg_wdata},
        {1'b1, 1'b1, 5'h1F, 32'hA5A5_0F0F});
    chk("t2_m1_busy", m1_busy, 1'b0);
    tick();
    chk("t2_core_req_low", core_dbg_req, 1'b0);

    // Round robin: both ports request writes every cycle
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, 5'h0A, DW'(i));
      set_req(1, 1'b1, 5'h15, DW'(100 + i));
      tick();
      if (i >= 1 && i <= 6) begin
        chk("t3_b2b_req", core_dbg_req, 1'b1);
        chk("t3_order", core_dbg_addr, (i % 2 == 1) ? 5'h0A : 5'h15);
      end
    end
    repeat (3) tick();

    // Read timeout with port 1 waiting behind it
    set_req(0, 1'b0, 5'h02, '0);
    tick();
    tick();
    core_rdy = 1'b0;
    set_req(1, 1'b1, 5'h04, 32'h0BAD_F00D);
    tick();
    tick();
    tick();
    chk("t4_not_yet", m0_rd_ready, 1'b0);
    tick();
    chk("t4_pulse", {m0_rd_ready, timeout_err}, 2'b11);
    chk("t4_rdata", m0_rdata, 32'hDEAD_BEEF);
    tick();
    chk("t4_next_grant", {core_dbg_req, core_dbg_addr}, {1'b1, 5'h04});
    tick();

    // Request while busy is dropped
    set_req(0, 1'b0, 5'h09, '0);
    tick();
    tick();
    set_req(0, 1'b0, 5'h07, '0);
    tick();
    core_rdy = 1'b1; core_rdata = 32'h5555_AAAA;
    tick();
    core_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_reissue", core_dbg_req, 1'b0);
    end

    // Reset during a read with port 1 pending
    set_req(0, 1'b0, 5'h01, '0);
    tick();
    tick();
    set_req(1, 1'b1, 5'h11, 32'h1111_2222);
    tick();
    rst_n = 1'b0;
    tick();
    check_zero("t6_reset");
    rst_n = 1'b1;
    core_rdy = 1'b1; core_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_quiet", {core_dbg_req, m0_rd_ready, m1_rd_ready}, 3'b000);
    end
    core_rdy = 1'b0;

    // Randomized traffic with occasional reset
    auto_resp = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_req(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      tick();
    end
    auto_resp = 0;
    rst_n = 1'b1;
    core_rdy = 1'b0;
    repeat (12) tick();

    chk("core_q_drained", 64'(core_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    chk("st_q_drained", 64'(st_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
